// File: rtl/axi_l2_mem_port_sched.sv
// AXI slave front-end for a single-port L2 SRAM: round-robin read/write burst
// scheduling, per-beat address generation, B response and 2-deep R return FIFO.
module axi_l2_mem_port_sched #(
  parameter int AXIADDRWD  = 32,
  parameter int AXIDATAWD  = 32,
  parameter int IDWD       = 4,
  parameter int MEM_ADDRWD = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDWD-1:0]        AWID,
  input  logic [AXIADDRWD-1:0]   AWADDR,
  input  logic [3:0]             AWLEN,
  input  logic [2:0]             AWSIZE,
  input  logic [1:0]             AWBURST,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [AXIDATAWD-1:0]   WDATA,
  input  logic [AXIDATAWD/8-1:0] WSTRB,
  input  logic                   WLAST,
  input  logic                   WVALID,
  output logic                   WREADY,
  input  logic [IDWD-1:0]        ARID,
  input  logic [AXIADDRWD-1:0]   ARADDR,
  input  logic [3:0]             ARLEN,
  input  logic [2:0]             ARSIZE,
  input  logic [1:0]             ARBURST,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [IDWD-1:0]        BID,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  output logic [IDWD-1:0]        RID,
  output logic [AXIDATAWD-1:0]   RDATA,
  output logic [1:0]             RRESP,
  output logic                   RLAST,
  output logic                   RVALID,
  input  logic                   RREADY,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [MEM_ADDRWD-1:0]  mem_addr,
  output logic [AXIDATAWD-1:0]   mem_wdata,
  output logic [AXIDATAWD/8-1:0] mem_be,
  input  logic [AXIDATAWD-1:0]   mem_rdata
);

  localparam int STRBWD = AXIDATAWD / 8;
  localparam int WSHIFT = $clog2(STRBWD);
  localparam int EW     = IDWD + AXIDATAWD + 3;

  // state    | meaning
  // IDLE     | arbitrate AW vs AR, latch the granted command
  // WR_BURST | one SRAM write per W handshake until AWLEN beats done
  // WR_RESP  | present B until accepted
  // RD_BURST | issue SRAM reads while the R FIFO has room
  typedef enum logic [1:0] {IDLE, WR_BURST, WR_RESP, RD_BURST} state_e;

  state_e                 state_q, state_d;
  logic                   last_wr_q, last_wr_d;
  logic [IDWD-1:0]        id_q, id_d;
  logic [AXIADDRWD-1:0]   addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [3:0]             beat_q, beat_d;
  logic                   err_q, err_d;
  logic                   inflight_q, inflight_d;
  logic [IDWD-1:0]        infl_id_q, infl_id_d;
  logic [1:0]             infl_resp_q, infl_resp_d;
  logic                   infl_last_q, infl_last_d;
  logic [EW-1:0]          fifo_q [2];
  logic [EW-1:0]          fifo_d [2];
  logic                   wptr_q, wptr_d;
  logic                   rptr_q, rptr_d;
  logic [1:0]             fcnt_q, fcnt_d;

  logic [AXIADDRWD-1:0]   incr_addr, wrap_mask, next_addr;
  logic                   pop, rd_ok, is_last;
  logic [2:0]             occ;

  always_comb begin
    incr_addr = addr_q + (AXIADDRWD'(1) << size_q);
    wrap_mask = ((AXIADDRWD'(len_q) + AXIADDRWD'(1)) << size_q) - AXIADDRWD'(1);
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    err_d       = err_q;
    inflight_d  = 1'b0;
    infl_id_d   = infl_id_q;
    infl_resp_d = infl_resp_q;
    infl_last_d = infl_last_q;
    fifo_d      = fifo_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    fcnt_d      = fcnt_q;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    ARREADY     = 1'b0;
    BID         = '0;
    BRESP       = 2'b00;
    BVALID      = 1'b0;
    RID         = '0;
    RDATA       = '0;
    RRESP       = 2'b00;
    RLAST       = 1'b0;
    RVALID      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = '0;
    pop         = 1'b0;
    rd_ok       = 1'b0;
    occ         = 3'd0;
    is_last     = (beat_q == len_q);

    if (!rst) begin
      pop = (fcnt_q != 2'd0) && RREADY;
      if (fcnt_q != 2'd0) begin
        RVALID = 1'b1;
        {RID, RDATA, RRESP, RLAST} = fifo_q[rptr_q];
      end

      case (state_q)
        IDLE: begin
          // A read waits for the previous read's last beat to land so that
          // in-flight metadata is never overwritten.
          rd_ok = ARVALID && !inflight_q;
          if (AWVALID && (!rd_ok || !last_wr_q)) begin
            AWREADY   = 1'b1;
            id_d      = AWID;
            addr_d    = AWADDR;
            len_d     = AWLEN;
            size_d    = AWSIZE;
            burst_d   = AWBURST;
            beat_d    = 4'd0;
            err_d     = (AWBURST == 2'b11);
            last_wr_d = 1'b1;
            state_d   = WR_BURST;
          end else if (rd_ok) begin
            ARREADY   = 1'b1;
            id_d      = ARID;
            addr_d    = ARADDR;
            len_d     = ARLEN;
            size_d    = ARSIZE;
            burst_d   = ARBURST;
            beat_d    = 4'd0;
            err_d     = (ARBURST == 2'b11);
            last_wr_d = 1'b0;
            state_d   = RD_BURST;
          end
        end
        WR_BURST: begin
          WREADY = 1'b1;
          if (WVALID) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = MEM_ADDRWD'(addr_q >> WSHIFT);
            mem_wdata = WDATA;
            mem_be    = WSTRB;
            addr_d    = next_addr;
            beat_d    = beat_q + 4'd1;
            if (WLAST != is_last) err_d = 1'b1;
            if (is_last) state_d = WR_RESP;
          end
        end
        WR_RESP: begin
          BVALID = 1'b1;
          BID    = id_q;
          BRESP  = err_q ? 2'b10 : 2'b00;
          if (BREADY) begin
            err_d   = 1'b0;
            state_d = IDLE;
          end
        end
        RD_BURST: begin
          occ = {1'b0, fcnt_q} + {2'b00, inflight_q} - {2'b00, pop};
          if (occ < 3'd2) begin
            mem_req     = 1'b1;
            mem_addr    = MEM_ADDRWD'(addr_q >> WSHIFT);
            mem_be      = '1;
            inflight_d  = 1'b1;
            infl_id_d   = id_q;
            infl_resp_d = err_q ? 2'b10 : 2'b00;
            infl_last_d = is_last;
            addr_d      = next_addr;
            beat_d      = beat_q + 4'd1;
            if (is_last) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (inflight_q) begin
        fifo_d[wptr_q] = {infl_id_q, mem_rdata, infl_resp_q, infl_last_q};
        wptr_d         = ~wptr_q;
      end
      if (pop) rptr_d = ~rptr_q;
      fcnt_d = fcnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_wr_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      infl_id_q   <= '0;
      infl_resp_q <= '0;
      infl_last_q <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      fcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      infl_id_q   <= infl_id_d;
      infl_resp_q <= infl_resp_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      fcnt_q      <= fcnt_d;
    end
  end

endmodule

// File: tb/tb_axi_l2_mem_port_sched.sv
// Scoreboard bench for axi_l2_mem_port_sched: directed bursts push expected SRAM
// accesses and B/R responses; a negedge monitor pops and compares them.
module tb_axi_l2_mem_port_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  AWID = '0, ARID = '0;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [3:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0;
  logic        AWVALID = 1'b0, ARVALID = 1'b0;
  logic        AWREADY, ARREADY, WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0, WVALID = 1'b0;
  logic [3:0]  BID, RID;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY = 1'b1;
  logic [31:0] RDATA;
  logic        RLAST, RVALID, RREADY = 1'b1;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  axi_l2_mem_port_sched #(.AXIADDRWD(32), .AXIDATAWD(32), .IDWD(4), .MEM_ADDRWD(16)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_pat(input logic [15:0] a);
    return {~a, a};
  endfunction

  function automatic logic [31:0] wr_pat(input logic [3:0] id, input logic [3:0] b);
    return {16'hA5A5, 4'h0, id, 4'h0, b};
  endfunction

  // SRAM model: read data valid the cycle after the request
  always @(posedge clk) if (mem_req && !mem_we) mem_rdata <= rd_pat(mem_addr);

  int n_chk = 0, n_fail = 0;
  logic [51:0] exp_mw[$];
  logic [15:0] exp_mr[$];
  logic [38:0] exp_r[$];
  logic [5:0]  exp_b[$];
  bit          grants[$];
  bit          sb_off = 1'b0;
  bit          rr_toggle = 1'b0, rr_hold = 1'b1;
  int          outst = 0;
  int          t_aw = -1, t_ar = -1, t_w0 = -1, t_b = -1;
  int          t_rd0 = -1, t_rdl = -1, t_rv0 = -1, t_rl = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event expected one", nm);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    RREADY = rr_toggle ? ~RREADY : rr_hold;
  end

  initial forever begin
    int rp;
    @(negedge clk);
    if (!rst) begin
      if (AWVALID && AWREADY) begin grants.push_back(1'b1); t_aw = cyc; end
      if (ARVALID && ARREADY) begin grants.push_back(1'b0); t_ar = cyc; end
      if (!sb_off) begin
        rp = (RVALID && RREADY) ? 1 : 0;
        if (mem_req && mem_we) begin
          if (exp_mw.size() == 0) fail_now("unexpected_mem_write");
          else chk("mem_write", 64'({mem_addr, mem_wdata, mem_be}), 64'(exp_mw.pop_front()));
          if (t_w0 < 0) t_w0 = cyc;
        end
        if (mem_req && !mem_we) begin
          if (exp_mr.size() == 0) fail_now("unexpected_mem_read");
          else chk("mem_read_addr", 64'(mem_addr), 64'(exp_mr.pop_front()));
          n_chk++;
          if (outst + 1 - rp > 2) begin
            n_fail++;
            $display("FAIL fifo_room: got %0d outstanding expected at most 2", outst + 1 - rp);
          end
          if (t_rd0 < 0) t_rd0 = cyc;
          t_rdl = cyc;
          outst++;
        end
        if (rp == 1) begin
          if (exp_r.size() == 0) fail_now("unexpected_r_beat");
          else chk("r_beat", 64'({RID, RDATA, RRESP, RLAST}), 64'(exp_r.pop_front()));
          if (t_rv0 < 0) t_rv0 = cyc;
          t_rl = cyc;
          outst--;
        end
        if (BVALID && t_b < 0) t_b = cyc;
        if (BVALID && BREADY) begin
          if (exp_b.size() == 0) fail_now("unexpected_b");
          else chk("b_resp", 64'({BID, BRESP}), 64'(exp_b.pop_front()));
        end
      end
    end
  end

  task automatic exp_rd(input logic [3:0] id, input logic [15:0] w, input logic [1:0] resp,
                        input logic last);
    exp_mr.push_back(w);
    exp_r.push_back({id, rd_pat(w), resp, last});
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (exp_r.size() == 0 && exp_b.size() == 0 && exp_mw.size() == 0 &&
          exp_mr.size() == 0 && outst == 0) return;
      @(negedge clk);
    end
    fail_now({nm, "_drain_timeout"});
    exp_r.delete(); exp_b.delete(); exp_mw.delete(); exp_mr.delete();
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input int last_at, input logic [1:0] resp,
                          input logic [15:0] w0, input logic [3:0] strb);
    int n;
    for (int b = 0; b <= int'(len); b++)
      exp_mw.push_back({w0 + 16'(b), wr_pat(id, 4'(b)), strb});
    exp_b.push_back({id, resp});
    t_w0 = -1; t_b = -1;
    @(posedge clk); #1;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!AWREADY && n < 50);
    if (!AWREADY) fail_now("aw_grant_timeout");
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      WVALID = 1'b1; WDATA = wr_pat(id, 4'(b)); WSTRB = strb; WLAST = (b == last_at);
      n = 0;
      do begin @(negedge clk); n++; end while (!WREADY && n < 50);
      if (!WREADY) fail_now("wready_timeout");
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    wait_drain("write");
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst);
    int n;
    t_rd0 = -1; t_rdl = -1; t_rv0 = -1; t_rl = -1;
    @(posedge clk); #1;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
    if (!ARREADY) fail_now("ar_grant_timeout");
    @(posedge clk); #1;
    ARVALID = 1'b0;
    wait_drain("read");
  endtask

  initial begin
    int n;
    // reset with both requests already pending
    AWID = 4'd1; AWADDR = 32'h200; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    ARID = 4'd2; ARADDR = 32'h300; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    WVALID = 1'b1; WDATA = wr_pat(4'd1, 4'd0); WSTRB = 4'hF; WLAST = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_wready",  64'(WREADY),  64'd0);
    chk("rst_bvalid",  64'(BVALID),  64'd0);
    chk("rst_rvalid",  64'({RVALID, RLAST, RID, RDATA, RRESP}), 64'd0);
    chk("rst_mem",     64'({mem_req, mem_we, mem_addr, mem_be}), 64'd0);

    for (int k = 0; k < 2; k++) begin
      exp_mw.push_back({16'h0080, wr_pat(4'd1, 4'd0), 4'hF});
      exp_b.push_back({4'd1, 2'b00});
      exp_rd(4'd2, 16'h00C0, 2'b00, 1'b1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (grants.size() < 4 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    chk("tie_grant_count", 64'(grants.size()), 64'd4);
    if (grants.size() >= 4)
      chk("tie_grant_order", 64'({grants[0], grants[1], grants[2], grants[3]}), 64'b1010);
    wait_drain("tie");

    do_write(4'd3, 32'h100, 4'd0, 2'b01, 0, 2'b00, 16'h0040, 4'hF);
    chk("wr1_first_beat_lat", 64'(t_w0 - t_aw), 64'd1);
    chk("wr1_bvalid_lat",     64'(t_b - t_aw),  64'd2);

    do_write(4'd5, 32'h1000, 4'd3, 2'b01, 3, 2'b00, 16'h0400, 4'h5);
    chk("wr4_bvalid_lat", 64'(t_b - t_aw), 64'd5);

    do_write(4'd7, 32'h2000, 4'd3, 2'b01, 1, 2'b10, 16'h0800, 4'hF);

    for (int i = 0; i < 4; i++) exp_rd(4'd4, 16'(i), 2'b00, i == 3);
    do_read(4'd4, 32'h0, 4'd3, 2'b01);
    chk("rd_first_req_lat", 64'(t_rd0 - t_ar), 64'd1);
    chk("rd_rvalid_lat",    64'(t_rv0 - t_ar), 64'd3);
    chk("rd_req_span",      64'(t_rdl - t_rd0), 64'd3);
    chk("rd_beat_span",     64'(t_rl - t_rv0), 64'd3);

    exp_rd(4'd6, 16'h000E, 2'b00, 1'b0);
    exp_rd(4'd6, 16'h000F, 2'b00, 1'b0);
    exp_rd(4'd6, 16'h000C, 2'b00, 1'b0);
    exp_rd(4'd6, 16'h000D, 2'b00, 1'b1);
    do_read(4'd6, 32'h38, 4'd3, 2'b10);

    for (int i = 0; i < 3; i++) exp_rd(4'd8, 16'h0008, 2'b00, i == 2);
    do_read(4'd8, 32'h20, 4'd2, 2'b00);

    exp_rd(4'd9, 16'h0004, 2'b10, 1'b0);
    exp_rd(4'd9, 16'h0005, 2'b10, 1'b1);
    do_read(4'd9, 32'h10, 4'd1, 2'b11);

    rr_toggle = 1'b1;
    for (int i = 0; i < 8; i++) exp_rd(4'd5, 16'h0100 + 16'(i), 2'b00, i == 7);
    do_read(4'd5, 32'h400, 4'd7, 2'b01);
    rr_toggle = 1'b0;

    // reset while a read burst is stalled on RREADY
    sb_off = 1'b1; rr_hold = 1'b0;
    @(posedge clk); #1;
    ARID = 4'd10; ARADDR = 32'h500; ARLEN = 4'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 50);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!RVALID && n < 20);
    if (!RVALID) fail_now("rvalid_before_reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid",  64'(RVALID),  64'd0);
    chk("midrst_mem_req", 64'(mem_req), 64'd0);
    chk("midrst_bvalid",  64'(BVALID),  64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (RVALID || mem_req) n++;
    end
    chk("midrst_quiet_cycles", 64'(n), 64'd0);
    outst = 0; rr_hold = 1'b1; sb_off = 1'b0;

    exp_rd(4'd11, 16'h0002, 2'b00, 1'b1);
    do_read(4'd11, 32'h8, 4'd0, 2'b01);
    do_write(4'd12, 32'h40, 4'd1, 2'b01, 1, 2'b00, 16'h0010, 4'hC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_l2_mem_port_sched.md
# axi_l2_mem_port_sched

Single-port L2 memory controller behind the target-side AXI NI receive path. It accepts AXI AW/W/AR requests from the NI and arbitrates between read and write bursts with a fair round-robin. Each granted burst is sequenced into one-beat-per-cycle accesses on a synchronous single-port SRAM. The block generates the B and R response channels back toward the NI send path.

## Interface
Parameters:
- AXIADDRWD, 32, AXI byte address width
- AXIDATAWD, 32, data width (8/16/32/64)
- IDWD, 4, AXI ID width
- MEM_ADDRWD, 16, SRAM word address width

Ports:
- clk  in  1  single clock
- rst  in  1  reset, synchronous, active-high
- AWID/AWADDR/AWLEN[3:0]/AWSIZE[2:0]/AWBURST[1:0]  in  IDWD/AXIADDRWD/4/3/2  write command
- AWVALID in 1, AWREADY out 1
- WDATA in AXIDATAWD; WSTRB in AXIDATAWD/8; WLAST, WVALID in 1; WREADY out 1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  same widths as AW  read command
- ARVALID in 1, ARREADY out 1
- BID out IDWD; BRESP out 2; BVALID out 1; BREADY in 1
- RID out IDWD; RDATA out AXIDATAWD; RRESP out 2; RLAST, RVALID out 1; RREADY in 1
- mem_req, mem_we  out  1  SRAM access strobe, write enable
- mem_addr  out  MEM_ADDRWD  word address = byte address >> log2(AXIDATAWD/8), truncated
- mem_wdata out AXIDATAWD; mem_be out AXIDATAWD/8; mem_rdata in AXIDATAWD; rdata valid exactly 1 cycle after a read mem_req

## Operation
- FSM states: IDLE, WR_BURST, WR_RESP, RD_BURST.
- IDLE arbitration:
  - AWVALID only: grant write. ARVALID only: grant read.
  - Both valid: grant the direction opposite to last_grant. last_grant resets to READ, so the first tie goes to write.
  - Grant drives AWREADY or ARREADY high combinationally for that cycle only.
  - The command is latched (ID, address, LEN, SIZE, BURST), the beat counter is cleared, and the FSM moves to WR_BURST or RD_BURST.
  - A read grant additionally requires R FIFO inflight==0, which prevents ID mixing hazards.
- Address generation per beat:
  - FIXED: address unchanged.
  - INCR: addr += 1<<SIZE.
  - WRAP: incremented, then wrapped at boundary (LEN+1)<<SIZE aligned down.
  - Reserved BURST=2'b11 is handled as INCR, and the burst's response is SLVERR.
- WR_BURST:
  - WREADY=1. Each W handshake drives mem_req=1, mem_we=1, mem_be=WSTRB, mem_wdata=WDATA in the same cycle.
  - Burst length is governed by AWLEN. When the beat counter reaches AWLEN, go to WR_RESP.
  - WLAST mismatch (early WLAST, or missing WLAST on the final beat) sets err.
- WR_RESP: BVALID=1, BID=latched ID, BRESP = err ? 2'b10 : 2'b00. Hold until BREADY, then go to IDLE and clear err.
- RD_BURST:
  - Issue a read (mem_req=1, mem_we=0, mem_be all ones) when fifo_count + inflight − pop < 2, where pop = RVALID & RREADY.
  - The returned beat is pushed with {RID, RDATA, RRESP, RLAST = beat==ARLEN}.
  - After the final beat is issued, go to IDLE; the FIFO keeps draining in parallel with any next write burst.
- R output comes from a 2-entry FIFO. RVALID = fifo not empty. Order is strictly preserved.
- mem_req is never asserted in IDLE or WR_RESP.

## Timing
- Reset values:
  - Outputs: AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, mem_req, mem_we = 0; BRESP, RRESP = 0; BID, RID, RDATA, mem_* = 0.
  - Internal: state=IDLE, FIFO empty, inflight=0, last_grant=READ.
- Reset asserted mid-burst: next cycle, all of the above hold. The pending burst is dropped and no B or R response is emitted.
- Write latency:
  - AW accepted at cycle T; WREADY is high from T+1.
  - LEN=N beats with WVALID continuous complete at T+1..T+N+1.
  - BVALID rises at T+N+2.
- Read latency:
  - AR accepted at T; first mem_req at T+1; RVALID at T+3.
  - With RREADY held high, throughput is 1 beat/cycle.
  - RLAST is on beat ARLEN.
- Turnaround: at least 1 IDLE cycle between bursts.
- Simultaneous pop and push on a full FIFO is legal; the count is unchanged.

## Test plan
- Single write: AWADDR=0x100, LEN=0, SIZE=2, WSTRB=0xF, WLAST=1 -> mem_addr=0x40, mem_we=1 at T+1; BVALID at T+2, BRESP=0.
- INCR read: ARADDR=0x0, LEN=3, SIZE=2, RREADY=1 -> mem_addr 0,1,2,3 on consecutive cycles; 4 R beats back-to-back with RLAST on the 4th.
- Tie arbitration: AWVALID and ARVALID both held from reset -> write granted first, read second, then alternating.
- Backpressure: read LEN=7 with RREADY toggling 1/0 -> mem_req never overruns the FIFO (count+inflight≤2); all 8 beats are in order with correct data.
- WRAP: ARADDR=0x38, LEN=3, SIZE=2 -> word addresses 0x0E,0x0F,0x0C,0x0D.
- Errors and reset:
  - Write LEN=3 with WLAST on beat 1 -> BRESP=2'b10 after 4 beats.
  - rst pulse in RD_BURST -> RVALID=0 and mem_req=0 the next cycle.
